// File: rtl/neuron_pkg.sv
// Shared constants and FSM state encoding for the neuron layer sequencer.
package neuron_pkg;

   localparam int NUM_TAPS    = 64;
   localparam int MAX_NEURONS = 16;
   localparam int ACC_W       = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_MAC,
      S_DRAIN,
      S_COMPARE,
      S_DONE
   } state_e;

endpackage

// File: rtl/layer_sequencer.sv
// Walks each neuron of a layer through clear / MAC taps / drain / threshold compare,
// producing memory addresses, MAC strobes and a per-neuron fire vector.
module layer_sequencer #(
   parameter int NUM_TAPS    = neuron_pkg::NUM_TAPS,
   parameter int MAX_NEURONS = neuron_pkg::MAX_NEURONS,
   parameter int ACC_W       = neuron_pkg::ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [4:0]              num_neurons,
   output logic                    busy,
   output logic                    done,
   output logic                    mac_clr,
   output logic                    mac_en,
   output logic [5:0]              in_addr,
   output logic [9:0]              wt_addr,
   output logic [3:0]              thr_addr,
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [ACC_W-1:0] thr,
   output logic [15:0]             out_vec
);
   import neuron_pkg::*;

   state_e      state_q, state_d;
   logic [5:0]  tap_q, tap_d;
   logic [3:0]  neuron_q, neuron_d;
   logic [4:0]  n_q, n_d;
   logic [15:0] out_vec_q, out_vec_d;
   logic        drain_q, drain_d;
   logic        done_q, done_d;
   logic        busy_q, mac_clr_q, mac_en_q;

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      neuron_d  = neuron_q;
      n_d       = n_q;
      out_vec_d = out_vec_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      if (abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         out_vec_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  n_d       = (num_neurons > 5'(MAX_NEURONS)) ? 5'(MAX_NEURONS) : num_neurons;
                  neuron_d  = '0;
                  out_vec_d = '0;
                  state_d   = (n_d != '0) ? S_CLEAR : S_DONE;
               end
            end
            S_CLEAR: begin
               tap_d   = '0;
               state_d = S_MAC;
            end
            S_MAC: begin
               tap_d   = tap_q + 6'd1;
               drain_d = 1'b0;
               if (tap_q == 6'(NUM_TAPS - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               // Two cycles: memory read latency then MAC pipeline latency
               drain_d = 1'b1;
               if (drain_q) state_d = S_COMPARE;
            end
            S_COMPARE: begin
               out_vec_d[neuron_q] = (acc >= thr);
               if ({1'b0, neuron_q} == n_q - 5'd1) begin
                  state_d = S_DONE;
               end else begin
                  neuron_d = neuron_q + 4'd1;
                  state_d  = S_CLEAR;
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tap_q     <= '0;
         neuron_q  <= '0;
         n_q       <= '0;
         out_vec_q <= '0;
         drain_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         mac_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         neuron_q  <= neuron_d;
         n_q       <= n_d;
         out_vec_q <= out_vec_d;
         drain_q   <= drain_d;
         done_q    <= done_d;
         busy_q    <= (state_d != S_IDLE);
         mac_clr_q <= (state_d == S_CLEAR);
         mac_en_q  <= (state_d == S_MAC);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mac_clr  = mac_clr_q;
   assign mac_en   = mac_en_q;
   assign in_addr  = tap_q;
   assign wt_addr  = {neuron_q, tap_q};
   assign thr_addr = neuron_q;
   assign out_vec  = out_vec_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized scoreboard bench for layer_sequencer with a per-layer reference model.
module tb_layer_sequencer;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [4:0]        num_neurons = '0;
   logic              busy, done, mac_clr, mac_en;
   logic [5:0]        in_addr;
   logic [9:0]        wt_addr;
   logic [3:0]        thr_addr;
   logic signed [15:0] acc, thr;
   logic [15:0]       out_vec;

   logic signed [15:0] acc_tbl [16];
   logic signed [15:0] thr_tbl [16];

   typedef struct {
      int          lat;
      logic [15:0] vec;
   } exp_t;
   exp_t sb_q [$];

   int checks = 0, errors = 0;
   int cyc = 0, start_cyc = 0;
   int l_clr = 0, l_en = 0, tap_i = 0;
   int addr_err = 0, both_cnt = 0, done_cnt = 0;
   logic busy_prev = 1'b0;

   layer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_neurons(num_neurons),
      .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
      .in_addr(in_addr), .wt_addr(wt_addr), .thr_addr(thr_addr),
      .acc(acc), .thr(thr), .out_vec(out_vec)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the MAC result and threshold memory, indexed by the neuron under compare
   always_comb begin
      acc = acc_tbl[thr_addr];
      thr = thr_tbl[thr_addr];
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Monitor: tracks strobe/address behaviour and scores every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (busy && !busy_prev) begin
            l_clr = 0;
            l_en  = 0;
         end
         if (mac_clr && mac_en) both_cnt++;
         if (mac_clr) begin
            l_clr++;
            tap_i = 0;
         end
         if (mac_en) begin
            if (int'(in_addr) != tap_i || int'(wt_addr[9:6]) != l_clr - 1 ||
                int'(wt_addr[5:0]) != tap_i) addr_err++;
            tap_i++;
            l_en++;
         end
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("done_latency", cyc - start_cyc, e.lat);
               chk("out_vec", int'(out_vec), int'(e.vec));
            end
         end
      end
      busy_prev = busy;
   end

   task automatic rand_tables();
      for (int i = 0; i < 16; i++) begin
         acc_tbl[i] = 16'(int'($urandom_range(0, 40)) - 20);
         thr_tbl[i] = 16'(int'($urandom_range(0, 40)) - 20);
      end
   endtask

   task automatic run_layer(input int nn, input bit inject);
      exp_t        e;
      int          n, d0, a0;
      logic [15:0] v;
      n = (nn > 16) ? 16 : nn;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = (acc_tbl[i] >= thr_tbl[i]);
      e.lat = 68 * n + 1;
      e.vec = v;
      sb_q.push_back(e);
      d0 = done_cnt;
      a0 = addr_err;
      @(negedge clk);
      num_neurons = 5'(nn);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_cyc = cyc;
      num_neurons = 5'($urandom);
      for (int i = 0; i < 1300 && done_cnt == d0; i++) begin
         @(negedge clk);
         start = (inject && n > 0 && i == 40);
      end
      start = 1'b0;
      chk("done_seen", done_cnt - d0, 1);
      chk("clr_pulses", l_clr, n);
      chk("mac_en_cycles", l_en, 64 * n);
      chk("addr_seq", addr_err - a0, 0);
      repeat (3) @(negedge clk);
      chk("out_vec_hold", int'(out_vec), int'(v));
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
      int d0;
      int found;
      for (int i = 0; i < 16; i++) begin
         acc_tbl[i] = '0;
         thr_tbl[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_strobes", int'({mac_clr, mac_en}), 0);
      chk("rst_addrs", int'({in_addr, wt_addr, thr_addr}), 0);
      chk("rst_out_vec", int'(out_vec), 0);
      rst = 1'b0;

      acc_tbl[0] = 16'sd100; thr_tbl[0] = 16'sd50;
      run_layer(1, 1'b0);

      acc_tbl[0] = 16'sd10;  thr_tbl[0] = 16'sd20;
      acc_tbl[1] = 16'sd20;  thr_tbl[1] = 16'sd20;
      acc_tbl[2] = -16'sd5;  thr_tbl[2] = -16'sd6;
      run_layer(3, 1'b1);

      run_layer(0, 1'b0);

      rand_tables();
      run_layer(20, 1'b1);

      // Abort at tap 30 of neuron 1, with neuron 0 already fired
      acc_tbl[0] = 16'sd5; thr_tbl[0] = 16'sd1;
      @(negedge clk);
      num_neurons = 5'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (mac_en && wt_addr[9:6] == 4'd1 && in_addr == 6'd30) found = 1;
         else @(negedge clk);
      end
      chk("abort_point_reached", found, 1);
      chk("pre_abort_out_vec", int'(out_vec), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_vec", int'(out_vec), 0);
      chk("abort_strobes", int'({mac_clr, mac_en}), 0);
      d0 = done_cnt;
      repeat (300) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);

      // Abort together with start in IDLE must not launch a layer
      @(negedge clk);
      num_neurons = 5'd2;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_over_start", int'(busy), 0);

      // Reset in the middle of neuron 1, neuron 0 fired
      @(negedge clk);
      num_neurons = 5'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      chk("pre_rst_mac_en", int'(mac_en), 1);
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_strobes", int'({done, mac_clr, mac_en}), 0);
      chk("midrst_addrs", int'({in_addr, wt_addr, thr_addr}), 0);
      chk("midrst_out_vec", int'(out_vec), 0);
      start = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      d0 = done_cnt;
      repeat (200) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);

      for (int r = 0; r < 6; r++) begin
         rand_tables();
         run_layer(int'($urandom_range(0, 31)), 1'($urandom));
      end

      chk("clr_en_overlap", both_cnt, 0);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d expected=0", cyc);
      $fatal(1);
   end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 64, meaning the number of MAC taps per neuron.
REQ-002 SHALL have parameter MAX_NEURONS, default 16, meaning the maximum neurons per layer.
REQ-003 SHALL have parameter ACC_W, default 16, meaning the signed accumulator and threshold width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: begins a layer when sampled high in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: cancels the layer in progress.
REQ-008 SHALL have port num_neurons, input, 5 bits: neuron count, latched at start.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the layer completes.
REQ-011 SHALL have port mac_clr, output, 1 bit: accumulator clear strobe.
REQ-012 SHALL have port mac_en, output, 1 bit: MAC enable for the current tap.
REQ-013 SHALL have port in_addr, output, 6 bits: input-memory read address, equal to the tap index.
REQ-014 SHALL have port wt_addr, output, 10 bits: weight-memory read address {neuron_idx[3:0], tap[5:0]}.
REQ-015 SHALL have port thr_addr, output, 4 bits: threshold-memory read address, equal to neuron_idx.
REQ-016 SHALL have port acc, input, ACC_W bits, signed: accumulator result from the MAC.
REQ-017 SHALL have port thr, input, ACC_W bits, signed: threshold for neuron_idx.
REQ-018 SHALL have port out_vec, output, 16 bits: fire bit per neuron, with bit i belonging to neuron i.

Function
REQ-019 SHALL implement the states IDLE, CLEAR, MAC, DRAIN, COMPARE, DONE.
REQ-020 SHALL, in IDLE with start high and abort low, latch N = min(num_neurons, 16), set neuron_idx=0, clear out_vec, and go to CLEAR if N>0, else to DONE.
REQ-021 SHALL, in CLEAR (1 cycle), drive mac_clr=1 and mac_en=0, set tap=0, then go to MAC.
REQ-022 SHALL, in MAC (NUM_TAPS cycles), drive mac_en=1 with in_addr/wt_addr from the current tap, increment tap each cycle, and go to DRAIN after tap==63.
REQ-023 SHALL hold DRAIN for exactly 2 cycles to cover 1-cycle memory latency plus 1-cycle MAC latency, with mac_en=0.
REQ-024 SHALL, in COMPARE (1 cycle), register out_vec[neuron_idx] <= (acc >= thr), signed compare, with thr_addr valid since CLEAR.
REQ-025 SHALL, on leaving COMPARE, go to DONE if neuron_idx==N-1, else increment neuron_idx and go to CLEAR.
REQ-026 SHALL, in DONE, assert done=1 for 1 cycle, then go to IDLE; out_vec is held until the next accepted start.
REQ-027 SHALL have a per-neuron latency of 68 cycles (1+64+2+1), and the start-accept to done-pulse time SHALL be 68*N+1 cycles.
REQ-028 SHALL ignore start outside IDLE; num_neurons changes after the latch SHALL have no effect.
REQ-029 SHALL, on abort high in any non-IDLE state, go to IDLE next cycle, deassert mac_en/mac_clr, clear out_vec, and not pulse done.
REQ-030 SHALL give abort priority over start in IDLE, so no layer starts.
REQ-031 SHALL treat num_neurons values 17..31 as 16.
REQ-032 SHALL register all outputs; mac_clr and mac_en SHALL never both be high.

Reset
REQ-033 SHALL, on rst high at a clock edge, enter IDLE with busy=0, done=0, mac_clr=0, mac_en=0, in_addr=0, wt_addr=0, thr_addr=0, out_vec=0, tap=0, neuron_idx=0.
REQ-034 SHALL give rst priority over abort and start, including mid-layer.

Structure
REQ-035 SHALL place the state typedef and the constants NUM_TAPS, MAX_NEURONS and ACC_W in shared package neuron_pkg.
REQ-036 SHALL be implemented as a single module with no sub-module; the tap and neuron counters are inline.

Verification
REQ-037 The bench SHALL cover: rst, then start with N=1, acc=100, thr=50 -> done 69 cycles after start, out_vec=16'h0001, and 64 mac_en cycles with in_addr 0..63.
REQ-038 The bench SHALL cover: N=3 with acc/thr per neuron (10/20, 20/20, -5/-6) -> out_vec=16'h0006, done at cycle 205, and wt_addr upper bits 0,1,2.
REQ-039 The bench SHALL cover: num_neurons=0 -> done 1 cycle after start, out_vec=0, and no mac_clr/mac_en.
REQ-040 The bench SHALL cover: num_neurons=20 -> exactly 16 CLEAR pulses and done at cycle 68*16+1.
REQ-041 The bench SHALL cover: abort at tap 30 of neuron 1 -> IDLE next cycle, busy=0, out_vec=0, and no done pulse.
REQ-042 The bench SHALL cover: rst during MAC, and start re-asserted while busy -> reset values next cycle, and the busy-time start is ignored.
